// File: rtl/bit_div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding
// and step-counter sizing.
package bit_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    ZERO = 2'd3
  } state_e;

  localparam int WIDTH_DEFAULT = 4;
  localparam int CNT_W         = $clog2(WIDTH_DEFAULT + 1);

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_4divider_sub_stage.sv
// Combinational N-bit trial subtractor: x - y as x + ~y + 1.
// borrow is high when y > x (no carry out of the top bit).
module sub_stage #(
  parameter int N = 5
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] sum;

  assign sum    = {1'b0, x} + {1'b0, y ^ {N{1'b1}}} + {{N{1'b0}}, 1'b1};
  assign diff   = sum[N-1:0];
  assign borrow = ~sum[N];

endmodule

// File: rtl/bit_4divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/done
// handshake. Define BIT_DIV_EARLY_EXIT_EN to finish a<b requests in one cycle.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// CALC  | one shift/trial-subtract step per cycle, WIDTH steps
// DONE  | result valid, done pulse
// ZERO  | divisor was zero, saturated result, done pulse
module bit_4divider
  import bit_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;

  // The remainder never exceeds the divisor between steps, so its top bit
  // only matters inside the trial subtract and is dropped by the shift.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[WIDTH];

  assign rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  sub_stage #(.N(WIDTH + 1)) u_sub (
    .x      (rem_sh),
    .y      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign rem_step = borrow ? rem_sh : diff;
  assign quo_step = {quo_q[WIDTH-2:0], ~borrow};

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    q_d        = q_q;
    r_d        = r_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (b == '0) begin
            state_d    = ZERO;
            q_d        = '1;
            r_d        = a;
            div_zero_d = 1'b1;
            done_d     = 1'b1;
          end
`ifdef BIT_DIV_EARLY_EXIT_EN
          else if (a < b) begin
            state_d    = DONE;
            q_d        = '0;
            r_d        = a;
            div_zero_d = 1'b0;
            done_d     = 1'b1;
          end
`endif
          else begin
            state_d = CALC;
            rem_d   = '0;
            quo_d   = a;
            dvs_d   = b;
            cnt_d   = '0;
          end
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d    = DONE;
          q_d        = quo_step;
          r_d        = rem_step[WIDTH-1:0];
          div_zero_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      DONE, ZERO: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      q_q        <= q_d;
      r_q        <= r_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_bit_4divider.sv
// Scoreboard bench for bit_4divider (WIDTH=4): expected results are queued at
// request time and compared when done pulses.
module tb_bit_4divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy, done, div_zero;
  logic [3:0] q, r;

  bit_4divider #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
    int acc;
    int lat;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;
  int   n_push = 0;
  int   n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic exp_t model(input int ta, input int tb_v, input int acc);
    exp_t e;
    e.a   = ta;
    e.b   = tb_v;
    e.acc = acc;
    if (tb_v == 0) begin
      e.q = 15; e.r = ta; e.dz = 1; e.lat = 1;
    end else begin
      e.q = ta / tb_v; e.r = ta % tb_v; e.dz = 0; e.lat = 5;
`ifdef BIT_DIV_EARLY_EXIT_EN
      if (ta < tb_v) e.lat = 1;
`endif
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", int'(done), 0);
      end else begin
        got = sb.pop_front();
        n_done++;
        check_eq("q", int'(q), got.q);
        check_eq("r", int'(r), got.r);
        check_eq("div_zero", int'(div_zero), got.dz);
        check_eq("latency", cyc + 1 - got.acc, got.lat);
        if (got.b != 0) begin
          check_eq("inv_qb_plus_r", int'(q) * got.b + int'(r), got.a);
          check_eq("inv_r_lt_b", int'(r < got.b), 1);
        end
      end
    end
  end

  // Drive one request for a single clock; at return we sit on the negedge
  // after the sampling edge.
  task automatic issue(input int ta, input int tb_v, input bit push);
    @(negedge clk);
    start = 1'b1;
    a     = 4'(ta);
    b     = 4'(tb_v);
    if (push) begin
      sb.push_back(model(ta, tb_v, cyc + 1));
      n_push++;
    end
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = int'(busy);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      n++;
    end
    if (busy) check_eq("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_eq("done_timeout", int'(done), 1);
  endtask

  int dir_a [7] = '{13, 15, 0, 7, 5, 6, 3};
  int dir_b [7] = '{ 4,  1, 9, 7, 0, 3, 7};

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_q", int'(q), 0);
    check_eq("rst_r", int'(r), 0);
    check_eq("rst_div_zero", int'(div_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, including divide-by-zero followed by a normal divide
    for (int i = 0; i < 7; i++) begin
      exp_t e;
      e = model(dir_a[i], dir_b[i], 0);
      issue(dir_a[i], dir_b[i], 1'b1);
      wait_idle();
      check_eq("busy_cycles", busy_cnt, e.lat);
      if (i == 0) begin
        repeat (3) @(negedge clk);
        check_eq("hold_q", int'(q), 3);
        check_eq("hold_r", int'(r), 1);
      end
    end

    // Start while busy and start in the done cycle are both ignored
    issue(12, 5, 1'b1);
    @(negedge clk);
    start = 1'b1; a = 4'd9; b = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1; a = 4'd9; b = 4'd2;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_done", int'(busy), 0);
    repeat (8) @(negedge clk);
    check_eq("busy_stays_low", int'(busy), 0);

    // Reset mid-operation abandons the divide with no done pulse
    issue(14, 3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_q", int'(q), 0);
    check_eq("midrst_r", int'(r), 0);
    check_eq("midrst_done", int'(done), 0);
    repeat (8) @(negedge clk);
    issue(14, 3, 1'b1);
    wait_idle();

    // Full sweep of all operand pairs
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        issue(ia, ib, 1'b1);
        wait_idle();
      end
    end

    repeat (4) @(negedge clk);
    check_eq("sb_empty", sb.size(), 0);
    check_eq("done_count", n_done, n_push);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
